// File: rtl/oled_init_module.sv
// SSD1306 power-up sequencer: waits DELAY_CYCLES after a request, then streams
// the command table to an IIC byte writer one byte per transaction.
module oled_init_module #(
    parameter int DELAY_CYCLES = 5000000,
    parameter int CMD_COUNT    = 25
) (
    input  logic       CLOCK,
    input  logic       RST_n,
    input  logic       init_start_sig,
    output logic       init_done_sig,
    output logic       iic_start_sig,
    output logic [7:0] iic_ctrl_byte,
    output logic [7:0] iic_data,
    input  logic       iic_done_sig,
    output logic       busy,
    output logic [2:0] state_dbg
);

    // Handshake: iic_start_sig is a level held with iic_data stable until the
    // writer returns a one-cycle iic_done_sig; done pulses are only honoured in SEND.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DELAY = 3'd1,
        S_LOAD  = 3'd2,
        S_SEND  = 3'd3,
        S_DONE  = 3'd4,
        S_REARM = 3'd5
    } state_t;

    localparam logic [4:0]  LAST_IDX  = 5'(CMD_COUNT - 1);
    localparam logic [23:0] DELAY_TGT = 24'(DELAY_CYCLES);

    state_t      state, state_n;
    logic [4:0]  index, index_n;
    logic [23:0] delay_cnt, delay_cnt_n;
    logic        iic_start_n;
    logic [7:0]  iic_data_n;
    logic        init_done_n;

    function automatic logic [7:0] cmd_byte(input logic [4:0] idx);
        logic [7:0] b;
        case (idx)
            5'd0:    b = 8'hAE;
            5'd1:    b = 8'hD5;
            5'd2:    b = 8'h80;
            5'd3:    b = 8'hA8;
            5'd4:    b = 8'h1F;
            5'd5:    b = 8'hD3;
            5'd6:    b = 8'h00;
            5'd7:    b = 8'h40;
            5'd8:    b = 8'h8D;
            5'd9:    b = 8'h14;
            5'd10:   b = 8'h20;
            5'd11:   b = 8'h00;
            5'd12:   b = 8'hA1;
            5'd13:   b = 8'hC8;
            5'd14:   b = 8'hDA;
            5'd15:   b = 8'h02;
            5'd16:   b = 8'h81;
            5'd17:   b = 8'h8F;
            5'd18:   b = 8'hD9;
            5'd19:   b = 8'hF1;
            5'd20:   b = 8'hDB;
            5'd21:   b = 8'h40;
            5'd22:   b = 8'hA4;
            5'd23:   b = 8'hA6;
            5'd24:   b = 8'hAF;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    always_ff @(posedge CLOCK or negedge RST_n) begin
        if (!RST_n) begin
            state         <= S_IDLE;
            index         <= 5'd0;
            delay_cnt     <= 24'd0;
            iic_start_sig <= 1'b0;
            iic_data      <= 8'h00;
            init_done_sig <= 1'b0;
        end else begin
            state         <= state_n;
            index         <= index_n;
            delay_cnt     <= delay_cnt_n;
            iic_start_sig <= iic_start_n;
            iic_data      <= iic_data_n;
            init_done_sig <= init_done_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (init_start_sig) state_n = S_DELAY;
            S_DELAY: if (delay_cnt == DELAY_TGT) state_n = S_LOAD;
            S_LOAD:  state_n = S_SEND;
            S_SEND: begin
                if (iic_done_sig) state_n = (index < LAST_IDX) ? S_LOAD : S_DONE;
            end
            S_DONE:  state_n = S_REARM;
            // A request still held after completion must not restart the sequence.
            S_REARM: if (!init_start_sig) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        index_n     = index;
        delay_cnt_n = delay_cnt;
        iic_start_n = iic_start_sig;
        iic_data_n  = iic_data;
        init_done_n = 1'b0;
        case (state)
            S_IDLE: begin
                index_n     = 5'd0;
                delay_cnt_n = 24'd0;
                iic_start_n = 1'b0;
            end
            S_DELAY: begin
                if (delay_cnt != DELAY_TGT) delay_cnt_n = delay_cnt + 24'd1;
            end
            S_LOAD: begin
                iic_data_n  = cmd_byte(index);
                iic_start_n = 1'b1;
            end
            S_SEND: begin
                if (iic_done_sig) begin
                    iic_start_n = 1'b0;
                    if (index < LAST_IDX) index_n = index + 5'd1;
                    else                  init_done_n = 1'b1;
                end
            end
            default: iic_start_n = 1'b0;
        endcase
    end

    assign busy          = (state != S_IDLE) && (state != S_REARM);
    assign iic_ctrl_byte = 8'h00;
    assign state_dbg     = state;

endmodule

// File: tb/tb_oled_init_module.sv
// Directed bench for oled_init_module: DELAY_CYCLES=4 instance plus a
// DELAY_CYCLES=0 instance, with an inline IIC writer acking 3 cycles after start.
module tb_oled_init_module;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DELAY = 3'd1;

    logic       clk;
    logic       rst_n;
    logic       req0, req1, ack0, ack1;
    logic       done0, done1, start0, start1, busy0, busy1;
    logic [7:0] ctrl0, ctrl1, data0, data1;
    logic [2:0] st0, st1;

    logic       sel;
    logic       obs_done, obs_start, obs_busy;
    logic [7:0] obs_data;
    logic [2:0] obs_st;

    int         vecs  = 0;
    int         fails = 0;
    logic [7:0] exp_tbl [0:24];

    oled_init_module #(.DELAY_CYCLES(4), .CMD_COUNT(25)) u_dut0 (
        .CLOCK(clk), .RST_n(rst_n), .init_start_sig(req0), .init_done_sig(done0),
        .iic_start_sig(start0), .iic_ctrl_byte(ctrl0), .iic_data(data0),
        .iic_done_sig(ack0), .busy(busy0), .state_dbg(st0)
    );

    oled_init_module #(.DELAY_CYCLES(0), .CMD_COUNT(25)) u_dut1 (
        .CLOCK(clk), .RST_n(rst_n), .init_start_sig(req1), .init_done_sig(done1),
        .iic_start_sig(start1), .iic_ctrl_byte(ctrl1), .iic_data(data1),
        .iic_done_sig(ack1), .busy(busy1), .state_dbg(st1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        obs_done  = sel ? done1  : done0;
        obs_start = sel ? start1 : start0;
        obs_busy  = sel ? busy1  : busy0;
        obs_data  = sel ? data1  : data0;
        obs_st    = sel ? st1    : st0;
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic v);
        if (sel) req1 = v; else req0 = v;
    endtask

    task automatic set_ack(input logic v);
        if (sel) ack1 = v; else ack0 = v;
    endtask

    // Entered #1 after the edge on which iic_start_sig rose for byte i.
    task automatic txn(input int i);
        chk("data", 32'(obs_data), 32'(exp_tbl[i]));
        chk("start_hi", 32'(obs_start), 32'd1);
        step;
        chk("hold_start", 32'(obs_start), 32'd1);
        chk("hold_data", 32'(obs_data), 32'(exp_tbl[i]));
        step;
        set_ack(1'b1);
        step;
        set_ack(1'b0);
        chk("ack_drop", 32'(obs_start), 32'd0);
        if (i < 24) begin
            chk("no_early_done", 32'(obs_done), 32'd0);
            step;
            chk("one_low_cycle", 32'(obs_start), 32'd1);
        end else begin
            chk("done_pulse", 32'(obs_done), 32'd1);
            chk("busy_in_done", 32'(obs_busy), 32'd1);
            step;
            chk("done_clear", 32'(obs_done), 32'd0);
            chk("busy_rearm", 32'(obs_busy), 32'd0);
        end
    endtask

    // Raise the request, check first-start latency, then run bytes in order.
    // drop_at lowers the request before that byte; abort_at returns before it.
    task automatic run_seq(input int exp_lat, input int drop_at, input int abort_at);
        int n;
        set_req(1'b1);
        n = 0;
        while (n < 50) begin
            step;
            n++;
            if (n == 1) chk("enter_delay", 32'(obs_st), 32'(ST_DELAY));
            if (obs_start) break;
        end
        chk("first_latency", 32'(n - 1), 32'(exp_lat));
        if (obs_start !== 1'b1) return;
        for (int i = 0; i < 25; i++) begin
            if (i == drop_at) set_req(1'b0);
            if (i == abort_at) return;
            txn(i);
        end
    endtask

    initial begin
        exp_tbl = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h1F, 8'hD3, 8'h00, 8'h40, 8'h8D,
                    8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h02, 8'h81, 8'h8F,
                    8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF};
        sel   = 1'b0;
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        ack0  = 1'b0;
        ack1  = 1'b0;

        // Reset held with request high: everything quiet.
        for (int c = 0; c < 4; c++) begin
            step;
            chk("rst_start", 32'(start0), 32'd0);
            chk("rst_busy", 32'(busy0), 32'd0);
        end
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_data", 32'(data0), 32'd0);
        chk("rst_ctrl", 32'(ctrl0), 32'd0);
        chk("rst_state", 32'(st0), 32'(ST_IDLE));
        chk("rst_start1", 32'(start1), 32'd0);
        chk("rst_busy1", 32'(busy1), 32'd0);
        req0  = 1'b0;
        req1  = 1'b0;
        rst_n = 1'b1;
        step;

        // Full run; request left high afterwards must not retrigger.
        run_seq(6, -1, -1);
        for (int c = 0; c < 50; c++) begin
            step;
            chk("held_no_start", 32'(start0), 32'd0);
            chk("held_no_busy", 32'(busy0), 32'd0);
        end
        set_req(1'b0);
        step;
        step;
        chk("rearm_to_idle", 32'(st0), 32'(ST_IDLE));
        chk("ctrl_const", 32'(ctrl0), 32'd0);

        // Request dropped during byte 10: sequence still completes.
        run_seq(6, 10, -1);
        step;
        chk("idle_after_drop", 32'(st0), 32'(ST_IDLE));

        // Reset while byte 5 is in flight.
        run_seq(6, -1, 5);
        step;
        chk("b5_inflight", 32'(start0), 32'd1);
        chk("b5_data", 32'(data0), 32'(exp_tbl[5]));
        rst_n = 1'b0;
        #1;
        chk("async_start", 32'(start0), 32'd0);
        chk("async_state", 32'(st0), 32'(ST_IDLE));
        chk("async_busy", 32'(busy0), 32'd0);
        chk("async_data", 32'(data0), 32'd0);
        set_req(1'b0);
        step;
        rst_n = 1'b1;
        step;
        set_ack(1'b1);
        step;
        set_ack(1'b0);
        chk("stray_ack_state", 32'(st0), 32'(ST_IDLE));
        chk("stray_ack_start", 32'(start0), 32'd0);
        run_seq(6, -1, -1);
        set_req(1'b0);
        step;
        step;

        // Zero power-up delay instance.
        sel = 1'b1;
        run_seq(2, -1, -1);
        set_req(1'b0);
        step;

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
